// File: rtl/lsu_mem_master.sv
// Purpose: RV32I load/store initiator driving the data-memory request port with strobes and lane-replicated data.
// Latency: faults complete 1 cycle after lsu_valid, stores 2 cycles, loads 3 cycles (immediate gnt/rvalid).
// Backpressure: lsu_stall holds the pipeline until done; mem_* stay stable while waiting for mem_gnt, bounded by TIMEOUT_CYC.
module lsu_mem_master #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic [1:0]        lsu_exc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_MISAL   = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_nxt;
    logic             tmo_hit;
    logic [2:0]       fn3_q;
    logic [1:0]       off_q;

    logic             dec_illegal;
    logic             dec_misal;
    logic [3:0]       dec_strb;
    logic [31:0]      dec_wdata;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_fmt;

    // Pipeline is held while a request is being decoded or is outstanding at the memory.
    assign lsu_stall = ((state == IDLE) && lsu_valid) || (state == REQ) || (state == RESP);

    // Counter saturates at the last allowed cycle so a late gnt cannot restart the budget for RESP.
    assign tmo_hit     = (tmo_cnt == CNT_LAST);
    assign tmo_cnt_nxt = tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;

    // Decode the incoming request: legality, alignment, byte strobes and lane-replicated store data.
    always_comb begin
        dec_illegal = 1'b0;
        dec_misal   = 1'b0;
        dec_strb    = 4'b0000;
        dec_wdata   = lsu_wdata;
        case (lsu_funct3)
            3'b000: begin
                dec_strb  = 4'b0001 << lsu_addr[1:0];
                dec_wdata = {4{lsu_wdata[7:0]}};
            end
            3'b001: begin
                dec_misal = lsu_addr[0];
                dec_strb  = 4'b0011 << {lsu_addr[1], 1'b0};
                dec_wdata = {2{lsu_wdata[15:0]}};
            end
            3'b010: begin
                dec_misal = |lsu_addr[1:0];
                dec_strb  = 4'b1111;
            end
            3'b100: begin
                dec_illegal = lsu_we;
            end
            3'b101: begin
                dec_illegal = lsu_we;
                dec_misal   = lsu_addr[0];
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (!lsu_we) begin
            dec_strb = 4'b0000;
        end
    end

    // Select the addressed lane of the returned word and extend it per the latched access type.
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (fn3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h000000, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0000, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // Transaction FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            fn3_q     <= 3'b000;
            off_q     <= 2'b00;
            lsu_done  <= 1'b0;
            lsu_rdata <= 32'h0;
            lsu_exc   <= EXC_OK;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    lsu_done <= 1'b0;
                    lsu_exc  <= EXC_OK;
                    if (lsu_valid) begin
                        if (dec_illegal) begin
                            lsu_done <= 1'b1;
                            lsu_exc  <= EXC_ILLEGAL;
                            state    <= DONE;
                        end else if (dec_misal) begin
                            lsu_done <= 1'b1;
                            lsu_exc  <= EXC_MISAL;
                            state    <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_we;
                            mem_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb <= dec_strb;
                            mem_wdata <= dec_wdata;
                            fn3_q     <= lsu_funct3;
                            off_q     <= lsu_addr[1:0];
                            tmo_cnt   <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt_nxt;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            lsu_done <= 1'b1;
                            lsu_exc  <= EXC_OK;
                            state    <= DONE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        lsu_done <= 1'b1;
                        lsu_exc  <= EXC_TIMEOUT;
                        state    <= DONE;
                    end
                end
                RESP: begin
                    tmo_cnt <= tmo_cnt_nxt;
                    if (mem_rvalid) begin
                        lsu_rdata <= ld_fmt;
                        lsu_done  <= 1'b1;
                        lsu_exc   <= EXC_OK;
                        state     <= DONE;
                    end else if (tmo_hit) begin
                        lsu_done <= 1'b1;
                        lsu_exc  <= EXC_TIMEOUT;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    lsu_done <= 1'b0;
                    lsu_exc  <= EXC_OK;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Purpose: randomized and directed bench for lsu_mem_master against a byte-level reference model.
// Latency: each transaction runs in a fixed 14-cycle window with cycle 0 = lsu_valid seen in IDLE.
// Backpressure: mem_gnt/mem_rvalid are delayed per transaction; TIMEOUT_CYC is 8 so timeouts fit the window.
module tb_lsu_mem_master;

    localparam int TMO   = 8;
    localparam int NEVER = 99;
    localparam int WIN   = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid, lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_done;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_exc;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int             obs_done_cyc, obs_done_cnt;
    logic [1:0]     obs_exc;
    logic [31:0]    obs_rdata, obs_addr, obs_wdata;
    logic [3:0]     obs_strb;
    logic [WIN-1:0] obs_req, obs_stall;
    bit             obs_unstable;
    logic [31:0]    m_last;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_exc(lsu_exc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] m_fault(bit we, logic [2:0] f3, logic [31:0] a);
        bit legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                    (((f3 == 3'd4) || (f3 == 3'd5)) && !we);
        if (!legal) return 2'b10;
        if ((int'(a[1:0]) % m_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_strb(bit we, logic [2:0] f3, logic [31:0] a);
        int v;
        if (!we) return 4'b0000;
        v = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
        logic [31:0] r;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        int     sz  = m_size(f3);
        longint raw = (longint'(w) >> (8 * int'(a[1:0]))) & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && raw >= (longint'(1) << (8 * sz - 1)))
            raw = raw - (longint'(1) << (8 * sz));
        return raw[31:0];
    endfunction

    function automatic bit m_timed_out(bit we, int g, int r);
        if (we) return (1 + g) > TMO;
        return (2 + g + r) > TMO;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        rst_n = 1'b1;
        m_last = 32'h0;
    endtask

    // Runs one request with gnt in cycle 1+g and rvalid in cycle 2+g+r, recording what the DUT did.
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int g, input int r, input logic [31:0] word);
        bit cap = 0;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_unstable = 0;
        obs_req = '0; obs_stall = '0; obs_exc = 2'b00; obs_rdata = 32'h0;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_strb = 4'h0;
        for (int c = 0; c < WIN; c++) begin
            lsu_valid  = (obs_done_cyc < 0);
            lsu_we     = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = d;
            mem_gnt    = (c == 1 + g);
            mem_rvalid = (c == 2 + g + r);
            mem_rdata  = mem_rvalid ? word : $urandom;
            #4;
            obs_req[c]   = mem_req;
            obs_stall[c] = lsu_stall;
            if (mem_req) begin
                if (!cap) begin
                    cap = 1; obs_addr = mem_addr; obs_strb = mem_wstrb; obs_wdata = mem_wdata;
                end else if (mem_addr !== obs_addr || mem_wstrb !== obs_strb || mem_wdata !== obs_wdata) begin
                    obs_unstable = 1;
                end
            end
            if (lsu_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_exc = lsu_exc; obs_rdata = lsu_rdata;
                end
            end
            step();
        end
        lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #4;
        tests_run++;
        if ({lsu_stall, lsu_done, lsu_rdata, lsu_exc, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got req=%b addr=%h strb=%b wdata=%h rdata=%h exc=%b want all zero",
                     mem_req, mem_addr, mem_wstrb, mem_wdata, lsu_rdata, lsu_exc);
        end
        step();
    endtask

    task automatic test_store_byte();
        do_txn(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h100 || obs_strb !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL sb_port got addr=%h strb=%b wdata=%h want 100 1000 a5a5a5a5", obs_addr, obs_strb, obs_wdata);
        end
        tests_run++;
        if (obs_done_cyc !== 2 || obs_exc !== 2'b00) begin
            tests_failed++;
            $display("FAIL sb_done got cycle=%0d exc=%b want 2 00", obs_done_cyc, obs_exc);
        end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ads [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        for (int i = 0; i < 5; i++) begin
            do_txn(0, f3s[i], ads[i], 32'h0, 0, 0, 32'h80FF7F01);
            tests_run++;
            if (obs_rdata !== exp[i] || obs_done_cyc !== 3 || obs_strb !== 4'b0000) begin
                tests_failed++;
                $display("FAIL load_fmt%0d got rdata=%h cycle=%0d strb=%b want %h 3 0000",
                         i, obs_rdata, obs_done_cyc, obs_strb, exp[i]);
            end
        end
        m_last = 32'h80FF7F01;
    endtask

    task automatic test_faults();
        bit          wes [4] = '{0, 1, 0, 1};
        logic [2:0]  f3s [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        logic [31:0] ads [4] = '{32'h101, 32'h100, 32'h100, 32'h203};
        logic [1:0]  exs [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            do_txn(wes[i], f3s[i], ads[i], 32'h1234, 0, 0, 32'h0);
            tests_run++;
            if (obs_done_cyc !== 1 || obs_exc !== exs[i] || obs_req !== '0 || obs_rdata !== m_last) begin
                tests_failed++;
                $display("FAIL fault%0d got cycle=%0d exc=%b req=%b rdata=%h want 1 %b 0 %h",
                         i, obs_done_cyc, obs_exc, obs_req, obs_rdata, exs[i], m_last);
            end
        end
    endtask

    task automatic test_gnt_delay();
        do_txn(1, 3'b001, 32'h202, 32'hCAFEBEEF, 3, 0, 32'h0);
        tests_run++;
        if (obs_strb !== 4'b1100 || obs_wdata !== 32'hBEEFBEEF || obs_addr !== 32'h200 || obs_unstable) begin
            tests_failed++;
            $display("FAIL sh_port got addr=%h strb=%b wdata=%h unstable=%0d want 200 1100 beefbeef 0",
                     obs_addr, obs_strb, obs_wdata, obs_unstable);
        end
        tests_run++;
        if (obs_req !== 14'h001E || obs_stall !== 14'h001F || obs_done_cyc !== 5) begin
            tests_failed++;
            $display("FAIL sh_timing got req=%b stall=%b cycle=%0d want 00000000011110 00000000011111 5",
                     obs_req, obs_stall, obs_done_cyc);
        end
    endtask

    task automatic test_timeout();
        do_txn(0, 3'b010, 32'h100, 32'h0, 0, 1, 32'h12345678);
        do_txn(0, 3'b010, 32'h100, 32'h0, NEVER, 0, 32'h0);
        tests_run++;
        if (obs_exc !== 2'b11 || obs_done_cyc !== TMO + 1 || obs_req !== 14'h01FE || obs_rdata !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL timeout got exc=%b cycle=%0d req=%b rdata=%h want 11 %0d 00000111111110 12345678",
                     obs_exc, obs_done_cyc, obs_req, obs_rdata, TMO + 1);
        end
        do_txn(1, 3'b010, 32'h400, 32'h55AA00FF, 0, 0, 32'h0);
        tests_run++;
        if (obs_exc !== 2'b00 || obs_done_cyc !== 2 || obs_strb !== 4'b1111 || obs_wdata !== 32'h55AA00FF) begin
            tests_failed++;
            $display("FAIL after_timeout got exc=%b cycle=%0d strb=%b wdata=%h want 00 2 1111 55aa00ff",
                     obs_exc, obs_done_cyc, obs_strb, obs_wdata);
        end
        m_last = 32'h12345678;
    endtask

    task automatic test_reset_in_resp();
        int dones = 0;
        lsu_valid = 1; lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
        mem_gnt = 0; mem_rvalid = 0;
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0; rst_n = 0;
        step();
        rst_n = 1; lsu_valid = 0;
        #4;
        tests_run++;
        if ({lsu_stall, lsu_done, lsu_rdata, lsu_exc, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL rst_resp_outputs got req=%b we=%b addr=%h rdata=%h done=%b want all zero",
                     mem_req, mem_we, mem_addr, lsu_rdata, lsu_done);
        end
        step();
        for (int c = 0; c < 6; c++) begin
            mem_rvalid = (c == 0); mem_rdata = 32'hDEADBEEF;
            #4;
            if (lsu_done) dones++;
            step();
        end
        mem_rvalid = 0;
        tests_run++;
        if (dones !== 0 || lsu_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_resp_stray got dones=%0d rdata=%h want 0 00000000", dones, lsu_rdata);
        end
    endtask

    task automatic test_random();
        logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] a, d, word, e_rdata;
        logic [1:0]  e_exc;
        logic [WIN-1:0] e_req;
        bit          we, tmo;
        int          g, r, e_done, req_end;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            if (f3[2] && $urandom_range(0, 3) != 0) we = 0;
            a = $urandom;
            if ($urandom_range(0, 1) != 0) a = a & ~(32'(m_size(f3)) - 32'd1);
            d = $urandom; word = $urandom;
            g = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            r = $urandom_range(0, 4);

            e_exc   = m_fault(we, f3, a);
            e_req   = '0;
            e_rdata = m_last;
            if (e_exc != 2'b00) begin
                e_done = 1;
            end else begin
                tmo     = m_timed_out(we, g, r);
                req_end = (g == NEVER) ? TMO : 1 + g;
                for (int k = 1; k <= req_end; k++) e_req[k] = 1'b1;
                if (tmo) begin
                    e_exc = 2'b11; e_done = TMO + 1;
                end else if (we) begin
                    e_done = 2 + g;
                end else begin
                    e_done = 3 + g + r; e_rdata = m_load(f3, a, word);
                end
            end
            m_last = e_rdata;

            do_txn(we, f3, a, d, g, r, word);
            tests_run++;
            if (obs_exc !== e_exc || obs_done_cyc !== e_done || obs_done_cnt !== 1 ||
                obs_rdata !== e_rdata || obs_req !== e_req) begin
                tests_failed++;
                $display("FAIL rand%0d we=%0d f3=%0d a=%h g=%0d r=%0d got exc=%b cyc=%0d n=%0d rd=%h req=%b want %b %0d 1 %h %b",
                         n, we, f3, a, g, r, obs_exc, obs_done_cyc, obs_done_cnt, obs_rdata, obs_req,
                         e_exc, e_done, e_rdata, e_req);
            end
            if (m_fault(we, f3, a) == 2'b00) begin
                tests_run++;
                if (obs_addr !== (a & 32'hFFFFFFFC) || obs_strb !== m_strb(we, f3, a) ||
                    (we && obs_wdata !== m_wdata(f3, d)) || obs_unstable) begin
                    tests_failed++;
                    $display("FAIL rand%0d_port got addr=%h strb=%b wdata=%h unstable=%0d want %h %b %h 0",
                             n, obs_addr, obs_strb, obs_wdata, obs_unstable,
                             a & 32'hFFFFFFFC, m_strb(we, f3, a), m_wdata(f3, d));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; lsu_valid = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; m_last = 0;
        test_reset();
        test_store_byte();
        test_load_format();
        test_faults();
        test_gnt_delay();
        test_timeout();
        test_reset_in_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
